// File: rtl/v2f_isqrt_seq.sv
// v2f_isqrt_seq: multi-cycle unsigned integer square root (restoring, one root bit per cycle)
// Ports: CLK/RST (sync, active-high); A/A_VALID/A_READY radicand handshake;
//        Y (root), R (floor remainder), Y_VALID/Y_READY result handshake.
// Optional: define V2F_ISQRT_ROUND_EN to round Y to nearest (R stays the floor remainder).
module v2f_isqrt_seq #(
  parameter int A_WIDTH = 32,
  parameter int Y_WIDTH = (A_WIDTH + 1) / 2,
  parameter int R_WIDTH = Y_WIDTH + 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [A_WIDTH-1:0] A,
  input  logic               A_VALID,
  output logic               A_READY,
  output logic [Y_WIDTH-1:0] Y,
  output logic [R_WIDTH-1:0] R,
  output logic               Y_VALID,
  input  logic               Y_READY
);
  localparam int AW2 = 2 * Y_WIDTH;
  localparam int CW  = $clog2(Y_WIDTH + 1);
  if (Y_WIDTH != (A_WIDTH + 1) / 2) begin : g_bad_y_width
    $error("v2f_isqrt_seq: Y_WIDTH must equal (A_WIDTH+1)/2");
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             r_state;
  logic [AW2-1:0]     r_a;
  logic [Y_WIDTH-1:0] r_root;
  logic [Y_WIDTH-1:0] r_y;
  logic [R_WIDTH:0]   r_rem;
  logic [R_WIDTH-1:0] r_r;
  logic [CW-1:0]      r_cnt;
  logic               r_a_ready;
  logic               r_y_valid;
  logic [R_WIDTH:0]   w_rem_sh;
  logic [R_WIDTH:0]   w_trial;
  logic [R_WIDTH:0]   w_rem_nx;
  logic               w_bit;
  logic [Y_WIDTH-1:0] w_root_nx;
  logic [Y_WIDTH-1:0] w_y_nx;
`ifdef V2F_ISQRT_ROUND_EN
  logic               w_up;
`endif
  assign A_READY = r_a_ready;
  assign Y_VALID = r_y_valid;
  assign Y       = r_y;
  assign R       = r_r;
  always_comb begin
    // bring down the next two radicand bits; the upper rem bits are always zero here
    w_rem_sh  = (R_WIDTH + 1)'({r_rem, r_a[AW2-1 -: 2]});
    w_trial   = (R_WIDTH + 1)'({r_root, 2'b01});
    w_bit     = w_rem_sh >= w_trial;
    w_rem_nx  = w_bit ? w_rem_sh - w_trial : w_rem_sh;
    w_root_nx = (r_root << 1) | Y_WIDTH'(w_bit);
`ifdef V2F_ISQRT_ROUND_EN
    // (f+0.5)^2 = f^2+f+0.25, so round up exactly when the remainder exceeds f
    w_up      = w_rem_nx > (R_WIDTH + 1)'(w_root_nx);
    w_y_nx    = (w_up && !(&w_root_nx)) ? w_root_nx + Y_WIDTH'(1) : w_root_nx;
`else
    w_y_nx    = w_root_nx;
`endif
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_root    <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_y       <= '0;
      r_r       <= '0;
      r_a_ready <= 1'b1;
      r_y_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (A_VALID) begin
          r_a       <= AW2'(A);
          r_root    <= '0;
          r_rem     <= '0;
          r_cnt     <= CW'(Y_WIDTH);
          r_a_ready <= 1'b0;
          r_state   <= CALC;
        end
        CALC: begin
          r_a    <= r_a << 2;
          r_root <= w_root_nx;
          r_rem  <= w_rem_nx;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_y       <= w_y_nx;
            r_r       <= w_rem_nx[R_WIDTH-1:0];
            r_y_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: if (Y_READY) begin
          r_y_valid <= 1'b0;
          r_a_ready <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
